// File: rtl/l1_l2_arbiter.sv
// Purpose: shares one L2 request port among L1 requesters (0=DCACHE 1=ICACHE 2=DMMU 3=IMMU);
//          round-robin grant, in-order write-data steering via a tracking FIFO, read returns routed by ID.
// Latency: req_valid -> l2_req_valid 1 cycle, >=2 cycles per request; write/read data paths combinational.
// Backpressure: l2_req_ready holds the grant; a full tracking FIFO masks writes only; l2_wr_ready -> wr_ready[head].
// Option: define L1_ARB_FIXED_PRIORITY_EN for fixed priority (lowest index wins) instead of round-robin.
module l1_l2_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 30,
  parameter int BURST_W     = 2,
  parameter int TRACK_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]         req_rnw,
  input  logic [NUM_REQ*4-1:0]       req_be,
  input  logic [NUM_REQ*BURST_W-1:0] req_len,
  input  logic [NUM_REQ-1:0]         wr_valid,
  output logic [NUM_REQ-1:0]         wr_ready,
  input  logic [NUM_REQ*32-1:0]      wr_data,
  output logic                       l2_req_valid,
  input  logic                       l2_req_ready,
  output logic [ADDR_W-1:0]          l2_req_addr,
  output logic                       l2_req_rnw,
  output logic [3:0]                 l2_req_be,
  output logic [BURST_W-1:0]         l2_req_len,
  output logic [1:0]                 l2_req_id,
  output logic                       l2_wr_valid,
  input  logic                       l2_wr_ready,
  output logic [31:0]                l2_wr_data,
  input  logic                       l2_rd_valid,
  input  logic [1:0]                 l2_rd_id,
  input  logic [31:0]                l2_rd_data,
  output logic [NUM_REQ-1:0]         rd_valid,
  output logic [31:0]                rd_data
);

  localparam int PW = $clog2(TRACK_DEPTH);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t             state;
  logic [1:0]         grant;
  logic               granted;
  logic               handshake;
  logic               push;
  logic               pop;
  logic               beat;
  logic               fifo_full;
  logic               fifo_empty;
  logic [NUM_REQ-1:0] eligible;
  logic               pick_vld;
  logic [1:0]         pick_id;

  logic [ADDR_W-1:0]  sel_addr;
  logic               sel_rnw;
  logic [3:0]         sel_be;
  logic [BURST_W-1:0] sel_len;
  logic               sel_rvalid;

  logic [1:0]         id_mem  [TRACK_DEPTH];
  logic [BURST_W-1:0] len_mem [TRACK_DEPTH];
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [PW:0]        count;
  logic [BURST_W-1:0] beat_cnt;
  logic [1:0]         head_id;
  logic [BURST_W-1:0] head_len;

`ifndef L1_ARB_FIXED_PRIORITY_EN
  logic [1:0]         rr_ptr;
`endif

  assign granted    = (state == GRANTED);
  assign handshake  = granted & l2_req_ready;
  assign push       = handshake & ~sel_rnw;
  assign fifo_full  = (count == (PW+1)'(TRACK_DEPTH));
  assign fifo_empty = (count == '0);
  assign head_id    = id_mem[rptr];
  assign head_len   = len_mem[rptr];

  // Mux the granted requester's request fields.
  always_comb begin
    sel_addr   = '0;
    sel_rnw    = 1'b0;
    sel_be     = '0;
    sel_len    = '0;
    sel_rvalid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == 2'(i)) begin
        sel_addr   = req_addr[i*ADDR_W +: ADDR_W];
        sel_rnw    = req_rnw[i];
        sel_be     = req_be[i*4 +: 4];
        sel_len    = req_len[i*BURST_W +: BURST_W];
        sel_rvalid = req_valid[i];
      end
    end
  end

  // A write is only eligible while the tracking FIFO has room; reads always are.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] & ~(~req_rnw[i] & fifo_full);
    end
  end

`ifdef L1_ARB_FIXED_PRIORITY_EN
  // Lowest-index eligible requester wins; scanning downward leaves the lowest hit.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (eligible[i]) begin
        pick_vld = 1'b1;
        pick_id  = 2'(i);
      end
    end
  end
`else
  // First eligible at or after rr_ptr; scanning offsets downward leaves the nearest hit.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == idx && eligible[j]) begin
          pick_vld = 1'b1;
          pick_id  = 2'(j);
        end
      end
    end
  end
`endif

  // Request FSM: latch a grant in IDLE, hold it until L2 accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
`ifndef L1_ARB_FIXED_PRIORITY_EN
      rr_ptr <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= pick_id;
            state <= GRANTED;
          end
        end
        GRANTED: begin
          if (l2_req_ready) begin
            state <= IDLE;
`ifndef L1_ARB_FIXED_PRIORITY_EN
            rr_ptr <= (grant == 2'(NUM_REQ-1)) ? 2'd0 : grant + 2'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign l2_req_valid = granted;
  assign l2_req_addr  = granted ? sel_addr : '0;
  assign l2_req_rnw   = granted ? sel_rnw  : 1'b0;
  assign l2_req_be    = granted ? sel_be   : '0;
  assign l2_req_len   = granted ? sel_len  : '0;
  assign l2_req_id    = granted ? grant    : '0;

  // One-cycle acceptance pulse back to the granted requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = handshake & (grant == 2'(i));
    end
  end

  // Steer write beats from the requester at the FIFO head only.
  always_comb begin
    l2_wr_valid = 1'b0;
    l2_wr_data  = '0;
    wr_ready    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!fifo_empty && head_id == 2'(i)) begin
        l2_wr_valid = wr_valid[i];
        l2_wr_data  = wr_data[i*32 +: 32];
        wr_ready[i] = l2_wr_ready;
      end
    end
  end

  assign beat = l2_wr_valid & l2_wr_ready;
  assign pop  = beat & (beat_cnt == head_len);

  // Write-tracking FIFO and beat counter; head entry retires on its last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      beat_cnt <= '0;
      for (int i = 0; i < TRACK_DEPTH; i++) begin
        id_mem[i]  <= '0;
        len_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        id_mem[wptr]  <= grant;
        len_mem[wptr] <= sel_len;
        wptr          <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop) beat_cnt <= '0;
      else if (beat) beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Read returns go to the requester named by l2_rd_id; data is broadcast.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_valid[i] = l2_rd_valid && (l2_rd_id == 2'(i));
    end
  end

  assign rd_data = l2_rd_data;

  // Requesters must hold their request until it is accepted.
  a_req_hold: assert property (@(posedge clk) disable iff (!rst_n) granted |-> sel_rvalid);

  // Read returns must name an existing requester.
  a_rd_id: assert property (@(posedge clk) disable iff (!rst_n) l2_rd_valid |-> (int'(l2_rd_id) < NUM_REQ));

endmodule

// File: doc/l1_l2_arbiter.md
Name: l1_l2_arbiter

Overview:
- Shares the single L2 memory request port between the L1 requesters: ID 0 = DCACHE, 1 = ICACHE, 2 = DMMU, 3 = IMMU.
- Round-robin arbitration on the request channel.
- In-order write-data steering through a write-tracking FIFO.
- Read-return routing by requester ID.
- Sits between the L1 cache/MMU units and the L2/bus adapter.

Parameters:
NUM_REQ, 2, number of L1 requesters (1..4)
ADDR_W, 30, word-address width
BURST_W, 2, burst length field width; len = beats-1
TRACK_DEPTH, 4, outstanding write requests awaiting data (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester request accepted
req_addr  in  NUM_REQ*ADDR_W  request word address
req_rnw  in  NUM_REQ  1 = read, 0 = write
req_be  in  NUM_REQ*4  byte enables
req_len  in  NUM_REQ*BURST_W  burst beats-1
wr_valid  in  NUM_REQ  per-requester write-data beat valid
wr_ready  out  NUM_REQ  write beat consumed
wr_data  in  NUM_REQ*32  write data
l2_req_valid  out  1  L2 request valid
l2_req_ready  in  1  L2 accepts request
l2_req_addr  out  ADDR_W  granted address
l2_req_rnw  out  1  granted rnw
l2_req_be  out  4  granted be
l2_req_len  out  BURST_W  granted len
l2_req_id  out  2  granted requester ID
l2_wr_valid  out  1  write beat valid
l2_wr_ready  in  1  L2 accepts write beat
l2_wr_data  out  32  write beat data
l2_rd_valid  in  1  read return beat
l2_rd_id  in  2  read return requester ID
l2_rd_data  in  32  read return data
rd_valid  out  NUM_REQ  routed read beat valid
rd_data  out  32  read data (broadcast)

Behaviour:
- Reset (async, rst_n=0): state IDLE; grant=0; rr pointer=0; FIFO empty; beat counter=0. All valid/ready outputs 0; l2_req_* data fields 0.
- Request FSM, IDLE:
  - Eligible = req_valid & ~(write & fifo_full).
  - Pick first eligible at or after rr pointer (wrapping); register grant; go GRANTED.
  - Nothing eligible: stay IDLE.
- Request FSM, GRANTED:
  - l2_req_valid=1; l2_req_* muxed from the granted requester; l2_req_id = grant.
  - On l2_req_ready: req_ready[grant]=1 for that cycle; rr pointer = grant+1 mod NUM_REQ; push {id, len} to FIFO if write; go IDLE.
  - Requester must hold req_* stable until req_ready. A drop is illegal and is flagged by a simulation assertion.
  - Minimum spacing is 2 cycles per request; latency from req_valid to l2_req_valid is 1 cycle.
- Write data path:
  - FIFO non-empty: l2_wr_valid = wr_valid[head.id]; l2_wr_data = wr_data[head.id]; wr_ready[head.id] = l2_wr_ready. wr_ready is 0 for all other requesters.
  - Beat counter increments per accepted beat. At count == head.len: pop the FIFO, clear the counter.
  - Write data is accepted only from the cycle after its request handshake (registered FIFO head).
  - Simultaneous push and pop is legal; occupancy unchanged.
  - Full FIFO masks write eligibility only; reads remain eligible.
- Read routing (combinational):
  - rd_valid[i] = l2_rd_valid && l2_rd_id==i; rd_data = l2_rd_data.
  - A return with l2_rd_id >= NUM_REQ is dropped and asserts in simulation.
- Reset mid-burst: FIFO and counter cleared. Upstream is reset together with this block.

Optional Feature:
- Macro: L1_ARB_FIXED_PRIORITY_EN.
- Defined: the rr pointer is removed; the lowest-index eligible requester always wins (DCACHE over ICACHE).
- Undefined: round-robin as described above.

Test Plan:
- Requesters 0 and 1 both request reads continuously with l2_req_ready=1 → l2_req_id sequence 0,1,0,1; each req_ready is a 1-cycle pulse 2 cycles after its previous grant.
- Requester 0 writes len=3, then wr_valid beats A,B,C,D with l2_wr_ready toggling 1,0,1,… → l2_wr_data A,B,C,D in order; FIFO empty after beat D; counter back to 0.
- Five write requests from requester 1 with no write data (TRACK_DEPTH=4) → first 4 granted; the 5th stalls with req_ready=0 while a read from requester 0 is still granted. One completed burst then lets the 5th through.
- l2_req_ready held 0 for 10 cycles during GRANTED → l2_req_valid stays 1 and l2_req_addr stays stable; no re-arbitration occurs.
- l2_rd_valid with l2_rd_id=1, data 0xDEADBEEF → rd_valid=2'b10, rd_data=0xDEADBEEF in the same cycle.
- rst_n pulsed low mid-write-burst (beat 2 of 4) → all outputs 0 immediately; after release, a new write request gets the FIFO head with counter 0.
